// File: rtl/mem_image_dumper.sv
// ============================================================================
// Module      : mem_image_dumper
// Description : Walks a synchronous-read memory port through addresses
//               0..DEPTH-1 and streams each word out on a valid/ready bus.
//               Optional macro MEM_DUMP_CHECKSUM_EN appends a sum beat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_image_dumper #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              auto_en,
    input  logic [31:0]       pc_in,
    input  logic [31:0]       prog_size,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_READ = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_SEND = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
`ifdef MEM_DUMP_CHECKSUM_EN
    localparam logic [2:0] S_CSUM = 3'd5;
`endif

    localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(DEPTH - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [ADDR_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_out_data;
    logic [ADDR_W-1:0] r_out_addr;
    logic              r_armed;
    logic              w_auto_trig;
    logic              w_trig;
    logic              w_last_word;
`ifdef MEM_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] r_sum;
`endif

    assign w_auto_trig = auto_en && r_armed && (pc_in > prog_size);
    assign w_trig      = start || w_auto_trig;
    assign w_last_word = (r_cnt == c_LAST);
    assign mem_addr    = r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_trig) w_next = S_READ;
            S_READ: w_next = S_WAIT;
            S_WAIT: w_next = S_SEND;
            S_SEND: begin
                if (out_ready) begin
`ifdef MEM_DUMP_CHECKSUM_EN
                    w_next = w_last_word ? S_CSUM : S_READ;
`else
                    w_next = w_last_word ? S_DONE : S_READ;
`endif
                end
            end
`ifdef MEM_DUMP_CHECKSUM_EN
            S_CSUM: if (out_ready) w_next = S_DONE;
`endif
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_rd_en = (r_state == S_READ);
        busy      = (r_state != S_IDLE);
        done      = (r_state == S_DONE);
        out_data  = r_out_data;
        out_addr  = r_out_addr;
`ifdef MEM_DUMP_CHECKSUM_EN
        out_valid = (r_state == S_SEND) || (r_state == S_CSUM);
        out_last  = (r_state == S_CSUM);
        if (r_state == S_CSUM) begin
            out_data = r_sum;
            out_addr = '0;
        end
`else
        out_valid = (r_state == S_SEND);
        out_last  = (r_state == S_SEND) && w_last_word;
`endif
    end

    // Datapath: the auto trigger is one-shot until the next reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_out_data <= '0;
            r_out_addr <= '0;
            r_armed    <= 1'b1;
`ifdef MEM_DUMP_CHECKSUM_EN
            r_sum      <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_auto_trig) r_armed <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
                    if (w_trig) r_sum <= '0;
`endif
                end
                S_WAIT: begin
                    r_out_data <= mem_rdata;
                    r_out_addr <= r_cnt;
                end
                S_SEND: begin
                    if (out_ready) begin
`ifdef MEM_DUMP_CHECKSUM_EN
                        r_sum <= r_sum + r_out_data;
`endif
                        if (!w_last_word) r_cnt <= r_cnt + ADDR_W'(1);
                    end
                end
                S_DONE: r_cnt <= '0;
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_image_dumper.sv
// ============================================================================
// Module      : tb_mem_image_dumper
// Description : Self-checking bench for mem_image_dumper against a
//               memory-array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_image_dumper;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
`ifdef MEM_DUMP_CHECKSUM_EN
    localparam int NB = DEPTH + 1;
`else
    localparam int NB = DEPTH;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          auto_en = 1'b0;
    logic [31:0]   pc_in = '0;
    logic [31:0]   prog_size = '0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_last;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [DEPTH];

    int n_tests = 0;
    int n_fail  = 0;

    mem_image_dumper #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .auto_en   (auto_en),
        .pc_in     (pc_in),
        .prog_size (prog_size),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory: data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Expected beat k as {data, addr, last}; beat DEPTH is the checksum.
    function automatic logic [37:0] exp_beat(input int k);
        logic [31:0] s;
        s = '0;
        if (k < DEPTH) return {mem[k], 5'(k), (k == NB - 1)};
        for (int i = 0; i < DEPTH; i++) s = s + mem[i];
        return {s, 5'd0, 1'b1};
    endfunction

    // Runs one dump; cyc counts edges since the trigger was sampled-in.
    task automatic do_dump(input logic use_start, input int mode, input int stall_beat,
                           input int stall_len, input int start_pulse_at);
        int          k = 0;
        int          cyc;
        int          first = -1;
        int          stall = 0;
        logic        holding = 1'b0;
        logic        prev_last_hs = 1'b0;
        logic        fin = 1'b0;
        logic [37:0] held = '0;
        if (use_start) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        cyc = 1;
        while (!fin && cyc < 3000) begin
            start = (cyc == start_pulse_at);
            if (out_valid && first < 0) begin
                first = cyc;
                check("first_valid_latency", 64'(first), 64'd3);
            end
            if (holding)
                check("backpressure_hold", {out_valid, out_data, out_addr, out_last}, {1'b1, held});
            holding = 1'b0;
            if (done) begin
                check("done_after_last", {prev_last_hs, 32'(k)}, {1'b1, 32'(NB)});
                fin = 1'b1;
            end else begin
                check("busy_during_dump", 64'(busy), 64'd1);
            end
            prev_last_hs = 1'b0;
            if (out_valid) begin
                if (k == stall_beat && stall < stall_len) begin
                    out_ready = 1'b0;
                    stall++;
                end else begin
                    out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                end
                if (out_ready) begin
                    check($sformatf("beat%0d", k), {out_data, out_addr, out_last}, exp_beat(k));
                    k++;
                    prev_last_hs = (k == NB);
                end else begin
                    holding = 1'b1;
                    held    = {out_data, out_addr, out_last};
                end
            end else begin
                check("last_without_valid", 64'(out_last), 64'd0);
                out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            tick();
            cyc++;
        end
        start     = 1'b0;
        out_ready = 1'b0;
        if (!fin) check("dump_timeout", 64'd0, 64'd1);
        check("idle_after_done", {busy, done, out_valid}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("no_requeued_dump", 64'(busy), 64'd0);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] prog;
        logic        aen;
        logic        st;
        logic        exp_busy;
    } vec_t;

    vec_t vt [11];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{32'd108,        32'd108,        1'b1, 1'b0, 1'b0};
        vt[1]  = '{32'd112,        32'd108,        1'b1, 1'b0, 1'b1};
        vt[2]  = '{32'd0,          32'd0,          1'b1, 1'b0, 1'b0};
        vt[3]  = '{32'd1,          32'd0,          1'b1, 1'b0, 1'b1};
        vt[4]  = '{32'h8000_0000,  32'd1,          1'b1, 1'b0, 1'b1};
        vt[5]  = '{32'd1,          32'h8000_0000,  1'b1, 1'b0, 1'b0};
        vt[6]  = '{32'd200,        32'd108,        1'b0, 1'b0, 1'b0};
        vt[7]  = '{32'd200,        32'd108,        1'b0, 1'b1, 1'b1};
        vt[8]  = '{32'd200,        32'd108,        1'b1, 1'b1, 1'b1};
        vt[9]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFE,  1'b1, 1'b0, 1'b1};
        vt[10] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 1'b0, 1'b0};

        for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i * 3);

        tick();
        check("reset_outputs", {mem_rd_en, mem_addr, out_valid, out_data, out_addr, out_last, busy, done},
              64'd0);
        do_reset();

        // Trigger decision table
        foreach (vt[i]) begin
            do_reset();
            auto_en   = vt[i].aen;
            pc_in     = vt[i].pc;
            prog_size = vt[i].prog;
            start     = vt[i].st;
            tick();
            start = 1'b0;
            check($sformatf("trig_tbl%0d", i), {busy, mem_rd_en, mem_addr}, {vt[i].exp_busy, vt[i].exp_busy, 5'd0});
        end
        do_reset();
        auto_en = 1'b0;

        // Basic, backpressured and ignored-start dumps
        do_dump(1'b1, 0, -1, 0, -1);
        do_dump(1'b1, 0, 5, 10, -1);
        do_dump(1'b1, 0, -1, 0, 20);

        // Start and auto trigger together: one dump, and armed is consumed
        do_reset();
        auto_en = 1'b1; pc_in = 32'd200; prog_size = 32'd108;
        start = 1'b1;
        tick();
        start = 1'b0;
        do_dump(1'b0, 0, -1, 0, -1);

        // Auto trigger as the PC steps past the program end
        do_reset();
        for (int pc = 100; pc <= 112; pc += 4) begin
            pc_in = 32'(pc);
            tick();
            check($sformatf("auto_pc%0d", pc), 64'(busy), 64'(pc > 108));
        end
        do_dump(1'b0, 0, -1, 0, -1);
        for (int pc = 116; pc <= 200; pc += 4) begin
            pc_in = 32'(pc);
            tick();
            check("auto_no_retrigger", 64'(busy), 64'd0);
        end
        do_reset();
        tick();
        check("auto_rearmed_by_reset", 64'(busy), 64'd1);
        do_reset();
        auto_en = 1'b0;

        // Reset abort at beat 10
        start = 1'b1;
        tick();
        start     = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 200 && !(out_valid && out_addr == 5'd10); c++) tick();
        check("reached_beat10", {out_valid, out_addr}, {1'b1, 5'd10});
        out_ready = 1'b0;
        reset     = 1'b1;
        tick();
        check("abort_outputs", {out_valid, mem_rd_en, busy, done}, 64'd0);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("abort_no_done", {busy, done}, 64'd0);
        end
        do_dump(1'b1, 0, -1, 0, -1);

        // Randomized contents and sink behaviour
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
            do_reset();
            do_dump(1'b1, 1, int'($urandom_range(0, NB - 1)), int'($urandom_range(0, 15)), -1);
        end

        // All-ones image: checksum wraps to 0xFFFFFFE0
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'hFFFF_FFFF;
        do_dump(1'b1, 0, -1, 0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
